// File: rtl/apb_sync_fifo_v2_pkg.sv
// Shared constants for the APB FIFO: register byte offsets, IRQ/CTRL bit positions.
// Also a byte-strobe merge helper for register writes.
package apb_fifo_v2_pkg;
  localparam logic [5:0] CTRL_OFS     = 6'h00;
  localparam logic [5:0] THRESH_OFS   = 6'h04;
  localparam logic [5:0] STATUS_OFS   = 6'h08;
  localparam logic [5:0] IRQ_STAT_OFS = 6'h0C;
  localparam logic [5:0] IRQ_EN_OFS   = 6'h10;
  localparam logic [5:0] DATA_OFS     = 6'h20;

  localparam int IRQ_OVF = 0;
  localparam int IRQ_UDF = 1;
  localparam int IRQ_AF  = 2;
  localparam int IRQ_AE  = 3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  typedef logic [3:0] irq_stat_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/apb_sync_fifo_v2_if.sv
// APB4 slave port bundle; the slave always answers with zero wait states.
interface apb_sync_fifo_v2_if;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport slave (input PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
                 output PREADY, PRDATA, PSLVERR);
  modport master (output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
                  input PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_sync_fifo_v2_core.sv
// FIFO storage with wrapping pointers and occupancy count; head entry is read combinationally.
// Caller guarantees no push when full, no pop when empty, and never both in one cycle.
module fifo_v2_core #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end
endmodule

// File: rtl/apb_sync_fifo_v2.sv
// APB4 FIFO: register decode, thresholds, sticky IRQ status and registered interrupt.
// Zero wait states; overflow/underflow/disabled accesses are refused with PSLVERR.
module apb_sync_fifo_v2
  import apb_fifo_v2_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_sync_fifo_v2_if.slave   apb,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                irq
);
  logic             access, wr, rd, hi_ok, mapped, err;
  logic [3:0]       ofs;
  logic             sel_ctrl, sel_thr, sel_stat, sel_irqs, sel_irqe, sel_data;
  logic             en, af_q, ae_q;
  logic [CW-1:0]    af_th, ae_th, count;
  irq_stat_t        stat, stat_set, stat_clr;
  logic [3:0]       irq_en;
  logic             push, pop, flush;
  logic [WIDTH-1:0] head;
  logic [31:0]      thr_val, wmerge, rd_val;
  logic             unused;

  assign access = apb.PSEL & apb.PENABLE;
  assign wr     = access & apb.PWRITE;
  assign rd     = access & ~apb.PWRITE;
  assign hi_ok  = (apb.PADDR[31:6] == 26'd0);
  assign ofs    = apb.PADDR[5:2];

  assign sel_ctrl = hi_ok && (ofs == CTRL_OFS[5:2]);
  assign sel_thr  = hi_ok && (ofs == THRESH_OFS[5:2]);
  assign sel_stat = hi_ok && (ofs == STATUS_OFS[5:2]);
  assign sel_irqs = hi_ok && (ofs == IRQ_STAT_OFS[5:2]);
  assign sel_irqe = hi_ok && (ofs == IRQ_EN_OFS[5:2]);
  assign sel_data = hi_ok && (ofs == DATA_OFS[5:2]);
  assign mapped   = sel_ctrl | sel_thr | sel_stat | sel_irqs | sel_irqe | sel_data;

  always_comb begin
    err = 1'b0;
    if (!mapped)                    err = 1'b1;
    else if (sel_stat && apb.PWRITE) err = 1'b1;
    else if (sel_data)              err = !en || (apb.PWRITE ? full : empty);
  end

  assign push  = wr & sel_data & en & ~full;
  assign pop   = rd & sel_data & en & ~empty;
  assign flush = wr & sel_ctrl & apb.PSTRB[0] & apb.PWDATA[CTRL_FLUSH];

  fifo_v2_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_core (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (apb.PWDATA[WIDTH-1:0]),
    .rdata (head),
    .count (count)
  );

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

  assign thr_val = (32'(ae_th) << 16) | 32'(af_th);
  assign wmerge  = strb_merge(thr_val, apb.PWDATA, apb.PSTRB);

  always_comb begin
    stat_set          = '0;
    stat_set[IRQ_OVF] = wr & sel_data & en & full;
    stat_set[IRQ_UDF] = rd & sel_data & en & empty;
    stat_set[IRQ_AF]  = almost_full & ~af_q;
    stat_set[IRQ_AE]  = almost_empty & ~ae_q;
  end
  assign stat_clr = (wr && sel_irqs && apb.PSTRB[0]) ? apb.PWDATA[3:0] : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en     <= 1'b1;
      af_th  <= CW'(DEPTH - 1);
      ae_th  <= CW'(1);
      stat   <= '0;
      irq_en <= '0;
      af_q   <= 1'b0;
      ae_q   <= 1'b1;
      irq    <= 1'b0;
    end else begin
      af_q <= almost_full;
      ae_q <= almost_empty;
      irq  <= |(stat & irq_en);
      // Hardware set takes priority over a simultaneous W1C clear.
      stat <= (stat & ~stat_clr) | stat_set;
      if (wr && sel_ctrl && apb.PSTRB[0]) en <= apb.PWDATA[CTRL_EN];
      if (wr && sel_thr) begin
        af_th <= wmerge[CW-1:0];
        ae_th <= wmerge[16 +: CW];
      end
      if (wr && sel_irqe && apb.PSTRB[0]) irq_en <= apb.PWDATA[3:0];
    end
  end

  always_comb begin
    rd_val = '0;
    if (sel_ctrl)      rd_val = 32'(en);
    else if (sel_thr)  rd_val = thr_val;
    else if (sel_stat) rd_val = (32'(count) << 16) |
                                32'({almost_full, almost_empty, full, empty});
    else if (sel_irqs) rd_val = 32'(stat);
    else if (sel_irqe) rd_val = 32'(irq_en);
    else if (sel_data) rd_val = 32'(head);
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PRDATA  = (rd && !err) ? rd_val : 32'd0;
  assign apb.PSLVERR = access & err;

  assign unused = ^{apb.PPROT, apb.PADDR[1:0], wmerge};
endmodule

// File: tb/tb_apb_sync_fifo_v2.sv
// Directed bench for apb_sync_fifo_v2 (WIDTH=8, DEPTH=16): register table plus FIFO sequences.
module tb_apb_sync_fifo_v2;
  import apb_fifo_v2_pkg::*;

  logic PCLK = 1'b0;
  logic PRESET;
  logic full, empty, almost_full, almost_empty, irq;
  int   tests = 0;
  int   fails = 0;

  apb_sync_fifo_v2_if bus();

  apb_sync_fifo_v2 #(.WIDTH(8), .DEPTH(16)) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .apb          (bus),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .irq          (irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdat, output logic e);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w;
    bus.PADDR = a; bus.PWDATA = d; bus.PSTRB = s;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    rdat = bus.PRDATA;
    e    = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    xfer(1'b1, 32'(a), d, 4'hF, r, e);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    xfer(1'b0, 32'(a), 32'd0, 4'h0, r, e);
    check(name, r, exp);
  endtask

  initial begin
    logic [31:0] r, d;
    logic        e;
    logic [7:0]  q[$];

    vt[0]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0000_0001, 1'b0};
    vt[1]  = '{1'b0, 32'h04,  32'h0,        4'h0, 32'h0001_000F, 1'b0};
    vt[2]  = '{1'b0, 32'h08,  32'h0,        4'h0, 32'h0000_0005, 1'b0};
    vt[3]  = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h0000_0000, 1'b0};
    vt[4]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h0000_0000, 1'b0};
    vt[5]  = '{1'b1, 32'h08,  32'hFFFF_FFFF, 4'hF, 32'h0,        1'b1};
    vt[6]  = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h0000_0000, 1'b1};
    vt[7]  = '{1'b0, 32'h14,  32'h0,        4'h0, 32'h0000_0000, 1'b1};
    vt[8]  = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0000_0000, 1'b1};
    vt[9]  = '{1'b1, 32'h04,  32'hFFFF_0005, 4'h3, 32'h0,        1'b0};
    vt[10] = '{1'b0, 32'h04,  32'h0,        4'h0, 32'h0001_0005, 1'b0};
    vt[11] = '{1'b1, 32'h04,  32'h0002_002F, 4'hF, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h04,  32'h0,        4'h0, 32'h0002_000F, 1'b0};
    vt[13] = '{1'b1, 32'h04,  32'h0001_000F, 4'hF, 32'h0,        1'b0};
    vt[14] = '{1'b1, 32'h10,  32'h0000_00FF, 4'hF, 32'h0,        1'b0};
    vt[15] = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h0000_000F, 1'b0};
    vt[16] = '{1'b1, 32'h10,  32'h0,        4'hF, 32'h0,        1'b0};
    vt[17] = '{1'b1, 32'h00,  32'h0,        4'h0, 32'h0,        1'b0};
    vt[18] = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0000_0001, 1'b0};
    vt[19] = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h0000_0000, 1'b0};

    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0;
    bus.PWDATA = 0; bus.PSTRB = 0; bus.PPROT = 0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("rst_flags", {27'd0, irq, almost_full, almost_empty, full, empty}, 32'h5);
    check("rst_pready", bus.PREADY, 32'd1);
    check("idle_prdata", bus.PRDATA, 32'd0);
    check("idle_pslverr", bus.PSLVERR, 32'd0);

    for (int i = 0; i < NV; i++) begin
      xfer(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].strb, r, e);
      if (!vt[i].w) check($sformatf("vec%0d_rdata", i), r, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), e, vt[i].exp_err);
    end

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 32'(DATA_OFS), 32'(8'hA5 + i), 4'hF, r, e);
      check("push_err", e, 32'd0);
    end
    check("full_flag", full, 32'd1);
    rd_chk("status_full", STATUS_OFS, 32'h0010_000A);
    xfer(1'b1, 32'(DATA_OFS), 32'h77, 4'hF, r, e);
    check("ovf_err", e, 32'd1);
    rd_chk("stat_ovf", IRQ_STAT_OFS, 32'h5);
    wr_reg(IRQ_STAT_OFS, 32'hF);

    // Drain in order, then underflow.
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
      check("pop_data", r, 32'(8'hA5 + i));
    end
    xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
    check("udf_rdata", r, 32'd0);
    check("udf_err", e, 32'd1);
    rd_chk("stat_udf", IRQ_STAT_OFS, 32'hA);
    wr_reg(IRQ_STAT_OFS, 32'hF);

    // Almost-full event and interrupt latency.
    wr_reg(THRESH_OFS, 32'h0001_0004);
    wr_reg(IRQ_EN_OFS, 32'h4);
    for (int i = 0; i < 4; i++) xfer(1'b1, 32'(DATA_OFS), 32'(i), 4'hF, r, e);
    check("af_flag", almost_full, 32'd1);
    check("irq_early0", irq, 32'd0);
    @(posedge PCLK); #1;
    check("irq_early1", irq, 32'd0);
    @(posedge PCLK); #1;
    check("irq_set", irq, 32'd1);
    rd_chk("stat_af", IRQ_STAT_OFS, 32'h4);
    wr_reg(IRQ_STAT_OFS, 32'h4);
    @(posedge PCLK); #1;
    check("irq_clr", irq, 32'd0);

    // Flush with data present.
    for (int i = 0; i < 3; i++) xfer(1'b1, 32'(DATA_OFS), 32'(i), 4'hF, r, e);
    wr_reg(CTRL_OFS, 32'h3);
    check("flush_empty", empty, 32'd1);
    rd_chk("status_flush", STATUS_OFS, 32'h0000_0005);
    rd_chk("ctrl_after_flush", CTRL_OFS, 32'h1);
    rd_chk("thresh_after_flush", THRESH_OFS, 32'h0001_0004);
    xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
    check("flush_pop_err", e, 32'd1);
    rd_chk("stat_flush", IRQ_STAT_OFS, 32'hA);
    wr_reg(IRQ_STAT_OFS, 32'hF);
    wr_reg(IRQ_EN_OFS, 32'h0);
    wr_reg(THRESH_OFS, 32'h0001_000F);

    // Pointer wrap with a few entries kept in flight.
    for (int i = 0; i < 40; i++) begin
      d = 32'((i * 37 + 11) & 255);
      xfer(1'b1, 32'(DATA_OFS), d, 4'hF, r, e);
      q.push_back(d[7:0]);
      if (i >= 3) begin
        xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
        check("wrap_pop", r, 32'(q.pop_front()));
      end
    end
    while (q.size() > 0) begin
      xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
      check("wrap_drain", r, 32'(q.pop_front()));
    end
    check("wrap_empty", empty, 32'd1);
    wr_reg(IRQ_STAT_OFS, 32'hF);

    // Disabled FIFO refuses data accesses without flagging.
    xfer(1'b1, 32'(CTRL_OFS), 32'h0, 4'h1, r, e);
    xfer(1'b1, 32'(DATA_OFS), 32'h55, 4'hF, r, e);
    check("dis_push_err", e, 32'd1);
    xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
    check("dis_pop_err", e, 32'd1);
    rd_chk("dis_status", STATUS_OFS, 32'h0000_0005);
    rd_chk("dis_stat", IRQ_STAT_OFS, 32'h0);
    wr_reg(CTRL_OFS, 32'h1);

    // Raise irq, then reset in the middle of a push.
    wr_reg(IRQ_EN_OFS, 32'hF);
    wr_reg(THRESH_OFS, 32'h0003_0007);
    xfer(1'b0, 32'(DATA_OFS), 32'd0, 4'h0, r, e);
    @(posedge PCLK); #1;
    check("irq_udf", irq, 32'd1);
    xfer(1'b1, 32'(DATA_OFS), 32'h11, 4'hF, r, e);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'(DATA_OFS); bus.PWDATA = 32'h22; bus.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; PRESET = 1'b0;
    check("mrst_irq", irq, 32'd0);
    check("mrst_flags", {28'd0, almost_full, almost_empty, full, empty}, 32'h5);
    rd_chk("mrst_status", STATUS_OFS, 32'h0000_0005);
    rd_chk("mrst_thresh", THRESH_OFS, 32'h0001_000F);
    rd_chk("mrst_irq_en", IRQ_EN_OFS, 32'h0);
    rd_chk("mrst_irq_stat", IRQ_STAT_OFS, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
